// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared types and constants for the DSP48A1 multiply-accumulate sequencer:
// FSM state encoding, slot tag codes and the OPMODE words each tag selects.
package dsp_mac_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_FIRST  = 2'd1,
    TAG_ACC    = 2'd2,
    TAG_BUBBLE = 2'd3
  } tag_t;

  // Pre-adder off, post-adder add, carry-in 0. Z in [3:2], X in [1:0].
  localparam logic [7:0] OPM_IDLE  = 8'b0000_0000;
  localparam logic [7:0] OPM_FIRST = 8'b0000_0001;
  localparam logic [7:0] OPM_ACC   = 8'b0000_1001;
  localparam logic [7:0] OPM_HOLD  = 8'b0000_1000;

  function automatic logic [7:0] tag_to_opmode(input tag_t tag);
    case (tag)
      TAG_FIRST:  return OPM_FIRST;
      TAG_ACC:    return OPM_ACC;
      TAG_BUBBLE: return OPM_HOLD;
      default:    return OPM_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/dsp_mac_sequencer_slot_pipe.sv
// Delays each per-cycle slot tag so its OPMODE reaches the slice in step with
// the matching product leaving the M register.
module dsp_mac_sequencer_slot_pipe
  import dsp_mac_sequencer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  tag_t       tag_in,
  output logic [7:0] opmode
);

  tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= TAG_NONE;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign opmode = tag_to_opmode(stage[DEPTH-1]);

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1 slice as a MAC engine: takes a job of N terms, streams N
// operand pairs with per-slot OPMODE, drains the pipeline and returns P.
module dsp_mac_sequencer
  import dsp_mac_sequencer_pkg::*;
#(
  parameter int LEN_W    = 16,
  parameter int MULT_LAT = 2,
  parameter int OP_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [17:0]      op_a,
  input  logic [17:0]      op_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  input  logic [47:0]      dsp_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output state_t           dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid & ready
  // are both 1. Ready/valid outputs here are registered; the sender may hold
  // or change its payload freely while valid is low.

  localparam int PIPE_DEPTH = 1 + MULT_LAT - OP_LAT;
  localparam int DRAIN_CYC  = MULT_LAT + 2;
  localparam int DCNT_W     = $clog2(DRAIN_CYC + 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYC);

  state_t            state;
  logic [LEN_W-1:0]  remaining;
  logic [DCNT_W-1:0] drain_cnt;
  logic              first_pending;
  logic              issue;
  tag_t              slot_tag;

  assign issue     = (state == ST_RUN) && op_valid && op_ready;
  assign dbg_state = state;

  always_comb begin
    slot_tag = TAG_NONE;
    if (state == ST_RUN) begin
      if (issue) slot_tag = first_pending ? TAG_FIRST : TAG_ACC;
      else       slot_tag = TAG_BUBBLE;
    end else if (state == ST_DRAIN) begin
      slot_tag = TAG_BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      job_ready     <= 1'b1;
      op_ready      <= 1'b0;
      res_valid     <= 1'b0;
      res_data      <= '0;
      dsp_a         <= '0;
      dsp_b         <= '0;
      dsp_ce        <= 1'b0;
      remaining     <= '0;
      drain_cnt     <= '0;
      first_pending <= 1'b0;
    end else begin
      dsp_a <= issue ? op_a : '0;
      dsp_b <= issue ? op_b : '0;
      case (state)
        ST_IDLE: begin
          if (job_valid) begin
            job_ready     <= 1'b0;
            remaining     <= job_len;
            first_pending <= 1'b1;
            if (job_len == '0) begin
              // Empty job: answer immediately without touching the slice.
              state     <= ST_RESULT;
              res_valid <= 1'b1;
              res_data  <= '0;
            end else begin
              state    <= ST_RUN;
              op_ready <= 1'b1;
              dsp_ce   <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            remaining     <= remaining - LEN_W'(1);
            first_pending <= 1'b0;
            if (remaining == LEN_W'(1)) begin
              state     <= ST_DRAIN;
              op_ready  <= 1'b0;
              drain_cnt <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            res_data  <= dsp_p;
            res_valid <= 1'b1;
            dsp_ce    <= 1'b0;
            state     <= ST_RESULT;
          end else begin
            drain_cnt <= drain_cnt + DCNT_W'(1);
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            job_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dsp_mac_sequencer_slot_pipe #(
    .DEPTH (PIPE_DEPTH)
  ) u_slot_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_in (slot_tag),
    .opmode (dsp_opmode)
  );

endmodule
